// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle RV32I sequencing controller:
//   FSM state encoding, opcode values, ALUOp/ALUControl codes and the
//   ResultSrc / ALUSrcA / ALUSrcB / ImmSrc select encodings.
//   No ports (package).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // Opcodes handled by the core
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp: what the ALU decoder is asked to produce
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op_i);
        logic [1:0] imm_v;
        case (op_i)
            OP_SW:   imm_v = IMM_S;
            OP_BEQ:  imm_v = IMM_B;
            OP_JAL:  imm_v = IMM_J;
            default: imm_v = IMM_I;
        endcase
        return imm_v;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// -----------------------------------------------------------------------------
// mc_alu_dec
//   Combinational ALU decoder.
//   Ports:
//     alu_op      in  2  00 add, 01 sub, 10 decode from funct fields
//     funct3      in  3  instr[14:12]
//     funct7b5    in  1  instr[30]
//     op_b5       in  1  instr[5] (distinguishes R-type from I-type)
//     alu_control out 3  ALUControl code
// -----------------------------------------------------------------------------
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output logic [2:0] alu_control
);

    // ALUOp / funct field decode
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi never subtracts: only R-type (op[5]=1) honours funct7b5
                    3'b000: begin
                        if (op_b5 && funct7b5) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Sequencing FSM for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU,
//   beq, jal; any other opcode traps). One memory port is shared between
//   instruction fetch and data access through a req/ready handshake.
//   Optional feature macro: MC_CTRL_PERF_EN builds cycle/instret counters;
//   without it both counter ports are tied to zero and no counter flops exist.
//   Ports:
//     clk, rst (async, active-low)
//     op[6:0], funct3[2:0], funct7b5, zero, mem_ready           -- inputs
//     mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite      -- strobes/addr
//     ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[1:0]    -- selects
//     ALUControl[2:0], illegal                                   -- ALU op, trap flag
//     cycle_cnt[CNT_W-1:0], instret_cnt[CNT_W-1:0]               -- perf counters
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e     state_q;
    state_e     state_d;

    logic       mem_req_s;
    logic       mem_write_s;
    logic       adr_src_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [2:0] alu_control_s;
    logic       illegal_s;

    mc_alu_dec u_alu_dec (
        .alu_op      (alu_op_s),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op_b5       (op[5]),
        .alu_control (alu_control_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d      = state_q;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RD2;
        alu_op_s     = ALUOP_ADD;
        illegal_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b0;
                alu_src_a_s = SRCA_PC;
                alu_src_b_s = SRCB_FOUR;
                alu_op_s    = ALUOP_ADD;
                // PC+4 is taken straight from the ALU the cycle the fetch completes
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    result_src_s = RES_ALURES;
                    state_d      = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch/jump target OldPC+imm is parked in ALUOut here
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
                case (op)
                    OP_LW:   state_d = S_MEMADR;
                    OP_SW:   state_d = S_MEMADR;
                    OP_R:    state_d = S_EXECR;
                    OP_I:    state_d = S_EXECI;
                    OP_BEQ:  state_d = S_BEQ;
                    OP_JAL:  state_d = S_JAL;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
                if (op == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_RD2;
                alu_op_s    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // PC <- target from DECODE while the ALU forms the link OldPC+4
                alu_src_a_s  = SRCA_OLDPC;
                alu_src_b_s  = SRCB_FOUR;
                alu_op_s     = ALUOP_ADD;
                result_src_s = RES_ALUOUT;
                pc_write_s   = 1'b1;
                state_d      = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a_s  = SRCA_RD1;
                alu_src_b_s  = SRCB_RD2;
                alu_op_s     = ALUOP_SUB;
                result_src_s = RES_ALUOUT;
                pc_write_s   = zero;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output stage: while reset is asserted every strobe and select reads 0,
    // so no write can escape in the cycle reset lands.
    always_comb begin
        if (rst) begin
            mem_req    = mem_req_s;
            MemWrite   = mem_write_s;
            AdrSrc     = adr_src_s;
            IRWrite    = ir_write_s;
            PCWrite    = pc_write_s;
            RegWrite   = reg_write_s;
            ResultSrc  = result_src_s;
            ALUSrcA    = alu_src_a_s;
            ALUSrcB    = alu_src_b_s;
            ImmSrc     = imm_src_of(op);
            ALUControl = alu_control_s;
            illegal    = illegal_s;
        end else begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 2'b00;
            ALUControl = 3'b000;
            illegal    = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q;
    logic [CNT_W-1:0] instret_cnt_d;
    logic             retire_s;

    // An instruction retires on the edge that takes the FSM back to FETCH
    always_comb begin
        retire_s = 1'b0;
        case (state_q)
            S_MEMWB:    retire_s = 1'b1;
            S_ALUWB:    retire_s = 1'b1;
            S_BEQ:      retire_s = 1'b1;
            S_MEMWRITE: retire_s = mem_ready;
            default:    retire_s = 1'b0;
        endcase
    end

    // Counter next values; both freeze while trapped
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1'b1);
            if (retire_s) begin
                instret_cnt_d = instret_cnt_q + CNT_W'(1'b1);
            end else begin
                instret_cnt_d = instret_cnt_q;
            end
        end else begin
            cycle_cnt_d   = cycle_cnt_q;
            instret_cnt_d = instret_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= {CNT_W{1'b0}};
            instret_cnt_q <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = {CNT_W{1'b0}};
    assign instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. The driver walks each instruction
//   through the phases its class needs, pushing the expected control vector
//   (with a care mask for fields that matter in that phase) and expected
//   counter values; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1110011;

    // Bit positions in the packed control vector
    localparam int B_ILL = 17, B_REQ = 16, B_MW = 15, B_IRW = 14, B_PCW = 13, B_RW = 12;
    localparam int B_ADR = 11, B_RES = 9, B_SA = 7, B_SB = 5, B_IMM = 3, B_ALU = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    typedef struct {
        logic [17:0] val;
        logic [17:0] care;
        logic [31:0] cyc;
        logic [31:0] ret;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_cyc  = 32'd0;
    logic [31:0] m_ret  = 32'd0;
    logic [6:0]  cur_op = 7'd0;
    logic [2:0]  cur_f3 = 3'd0;
    logic        cur_f7 = 1'b0;

    function automatic exp_t put(exp_t e, int lsb, int w, logic [2:0] v);
        for (int i = 0; i < w; i++) begin
            e.val[lsb+i]  = v[i];
            e.care[lsb+i] = 1'b1;
        end
        return e;
    endfunction

    // Strobes and illegal always matter; ImmSrc matters for opcodes with an immediate format
    function automatic exp_t base(string tag);
        exp_t e;
        e.val  = 18'd0;
        e.care = 18'h3F000;
        e.cyc  = 32'd0;
        e.ret  = 32'd0;
        e.tag  = tag;
        if (cur_op == T_LW || cur_op == T_I) e = put(e, B_IMM, 2, 3'b000);
        else if (cur_op == T_SW)             e = put(e, B_IMM, 2, 3'b001);
        else if (cur_op == T_BEQ)            e = put(e, B_IMM, 2, 3'b010);
        else if (cur_op == T_JAL)            e = put(e, B_IMM, 2, 3'b011);
        return e;
    endfunction

    // Arithmetic the instruction asks for, by funct3 (sub only for R-type with funct7b5)
    function automatic logic [2:0] alu_for(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (o == T_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t fetch_e();
        exp_t e;
        e = base("fetch");
        e = put(e, B_REQ, 1, 3'b001);
        e = put(e, B_ADR, 1, 3'b000);
        e = put(e, B_SA, 2, 3'b000);
        e = put(e, B_SB, 2, 3'b010);
        e = put(e, B_ALU, 3, 3'b000);
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus plus its expected response
    task automatic cyc(input exp_t e, input logic rdy, input logic z, input logic rv,
                       input bit trap, input bit retire);
        @(posedge clk);
        #1;
        rst       = rv;
        mem_ready = rdy;
        zero      = z;
        op        = cur_op;
        funct3    = cur_f3;
        funct7b5  = cur_f7;
        if (!rv) begin
            m_cyc = 32'd0;
            m_ret = 32'd0;
        end
`ifdef MC_CTRL_PERF_EN
        e.cyc = m_cyc;
        e.ret = m_ret;
`else
        e.cyc = 32'd0;
        e.ret = 32'd0;
`endif
        exp_q.push_back(e);
        if (rv) begin
            if (!trap) m_cyc = m_cyc + 32'd1;
            if (retire) m_ret = m_ret + 32'd1;
        end
    endtask

    task automatic do_reset(input int n, input logic rdy);
        exp_t e;
        e.val  = 18'd0;
        e.care = 18'h3FFFF;
        e.tag  = "reset";
        for (int i = 0; i < n; i++) cyc(e, rdy, rbit(), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input bit abort);
        exp_t e;
        cur_op = o;
        cur_f3 = f3;
        cur_f7 = f7;
        for (int i = 0; i < fw; i++) cyc(fetch_e(), 1'b0, rbit(), 1'b1, 1'b0, 1'b0);
        e = fetch_e();
        e.tag = "fetch_done";
        e = put(e, B_IRW, 1, 3'b001);
        e = put(e, B_PCW, 1, 3'b001);
        e = put(e, B_RES, 2, 3'b010);
        cyc(e, 1'b1, rbit(), 1'b1, 1'b0, 1'b0);
        e = base("decode");
        e = put(e, B_SA, 2, 3'b001);
        e = put(e, B_SB, 2, 3'b001);
        e = put(e, B_ALU, 3, 3'b000);
        cyc(e, rbit(), rbit(), 1'b1, 1'b0, 1'b0);
        if (o == T_LW || o == T_SW) begin
            e = base("memadr");
            e = put(e, B_SA, 2, 3'b010);
            e = put(e, B_SB, 2, 3'b001);
            e = put(e, B_ALU, 3, 3'b000);
            cyc(e, rbit(), rbit(), 1'b1, 1'b0, 1'b0);
            e = base(o == T_LW ? "memread" : "memwrite");
            e = put(e, B_REQ, 1, 3'b001);
            e = put(e, B_ADR, 1, 3'b001);
            if (o == T_SW) e = put(e, B_MW, 1, 3'b001);
            if (abort) begin
                cyc(e, 1'b0, rbit(), 1'b1, 1'b0, 1'b0);
                do_reset(1, 1'b0);
                return;
            end
            for (int i = 0; i < mw; i++) cyc(e, 1'b0, rbit(), 1'b1, 1'b0, 1'b0);
            cyc(e, 1'b1, rbit(), 1'b1, 1'b0, (o == T_SW));
            if (o == T_LW) begin
                e = base("memwb");
                e = put(e, B_RES, 2, 3'b001);
                e = put(e, B_RW, 1, 3'b001);
                cyc(e, rbit(), rbit(), 1'b1, 1'b0, 1'b1);
            end
        end else if (o == T_R || o == T_I || o == T_JAL) begin
            e = base(o == T_R ? "execr" : (o == T_I ? "execi" : "jal"));
            if (o == T_JAL) begin
                e = put(e, B_SA, 2, 3'b001);
                e = put(e, B_SB, 2, 3'b010);
                e = put(e, B_ALU, 3, 3'b000);
                e = put(e, B_RES, 2, 3'b000);
                e = put(e, B_PCW, 1, 3'b001);
            end else begin
                e = put(e, B_SA, 2, 3'b010);
                e = put(e, B_SB, 2, (o == T_R) ? 3'b000 : 3'b001);
                e = put(e, B_ALU, 3, alu_for(o, f3, f7));
            end
            cyc(e, rbit(), rbit(), 1'b1, 1'b0, 1'b0);
            e = base("aluwb");
            e = put(e, B_RES, 2, 3'b000);
            e = put(e, B_RW, 1, 3'b001);
            cyc(e, rbit(), rbit(), 1'b1, 1'b0, 1'b1);
        end else if (o == T_BEQ) begin
            e = base("beq");
            e = put(e, B_SA, 2, 3'b010);
            e = put(e, B_SB, 2, 3'b000);
            e = put(e, B_ALU, 3, 3'b001);
            e = put(e, B_RES, 2, 3'b000);
            e = put(e, B_PCW, 1, {2'b00, z});
            cyc(e, rbit(), z, 1'b1, 1'b0, 1'b1);
        end else begin
            e = base("trap");
            e = put(e, B_ILL, 1, 3'b001);
            for (int i = 0; i < 3; i++) cyc(e, rbit(), rbit(), 1'b1, 1'b1, 1'b0);
            do_reset(1, rbit());
        end
    endtask

    exp_t        mon_e;
    logic [17:0] mon_got;

    // Monitor: compare the DUT against the oldest expected record each falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {illegal, mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
            n_cmp++;
            if (((mon_got ^ mon_e.val) & mon_e.care) !== 18'd0) begin
                n_fail++;
                $display("FAIL %s: controls got %h expected %h (care %h) at %0t",
                         mon_e.tag, mon_got, mon_e.val, mon_e.care, $time);
            end
            n_cmp++;
            if (cycle_cnt !== mon_e.cyc) begin
                n_fail++;
                $display("FAIL %s cycle_cnt: got %0d expected %0d", mon_e.tag, cycle_cnt, mon_e.cyc);
            end
            n_cmp++;
            if (instret_cnt !== mon_e.ret) begin
                n_fail++;
                $display("FAIL %s instret_cnt: got %0d expected %0d", mon_e.tag, instret_cnt, mon_e.ret);
            end
        end
    end

    logic [6:0] ops [7];
    logic [2:0] f3s [5];

    initial begin
        rst = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_R; ops[3] = T_I;
        ops[4] = T_BEQ; ops[5] = T_JAL; ops[6] = T_BAD;
        f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111; f3s[4] = 3'b100;

        do_reset(2, 1'b0);
        // lw with two wait cycles in fetch and in memread
        run_instr(T_LW, 3'b010, 1'b0, 1'b0, 2, 2, 1'b0);
        // sw with a zero-wait memory
        run_instr(T_SW, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
        // R-type sub
        run_instr(T_R, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
        // beq taken then not taken
        run_instr(T_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
        run_instr(T_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        // illegal opcode traps until reset
        run_instr(T_BAD, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        // reset lands in a pending store
        run_instr(T_SW, 3'b010, 1'b0, 1'b0, 1, 0, 1'b1);
        run_instr(T_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            logic [6:0] o;
            o = ops[$urandom_range(0, 6)];
            run_instr(o, f3s[$urandom_range(0, 4)], rbit(), rbit(),
                      $urandom_range(0, 2), $urandom_range(0, 2),
                      (o == T_SW) && ($urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
